// File: rtl/mc_if_pkg.sv
// Shared definitions for the personality-to-MC request/response interface.
// Holds bus widths and the load-response payload carried through the
// responder pipeline and response queue.
package mc_if_pkg;

   localparam int unsigned REQ_ADDR_W = 48;
   localparam int unsigned REQ_DATA_W = 64;
   localparam int unsigned RDCTL_W    = 32;

   // Load response payload: returned tag plus read data
   typedef struct packed {
      logic [RDCTL_W-1:0]    rdctl;
      logic [REQ_DATA_W-1:0] data;
   } rsp_t;

endpackage

// File: rtl/mc_rspq.sv
// Synchronous response FIFO of rsp_t.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   i_push      - write i_data (ignored when full unless popping same cycle)
//   i_pop       - consume head (ignored when empty)
//   i_data      - entry to write
//   o_head_c    - current head entry (combinational)
//   o_full_c    - queue full (combinational)
//   o_empty_c   - queue empty (combinational)
//   o_count     - number of stored entries (registered)
module mc_rspq
   import mc_if_pkg::*;
#(
   parameter int unsigned DEPTH = 16
)
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_push,
   input  logic                    i_pop,
   input  rsp_t                    i_data,
   output rsp_t                    o_head_c,
   output logic                    o_full_c,
   output logic                    o_empty_c,
   output logic [$clog2(DEPTH):0]  o_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   rsp_t          r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic          w_wr;
   logic          w_rd;

   assign o_full_c  = (r_count == CW'(DEPTH));
   assign o_empty_c = (r_count == '0);
   assign o_head_c  = r_mem[r_rptr];
   assign o_count   = r_count;

   // A write into a full queue is legal when the head leaves the same cycle
   assign w_rd = i_pop & ~o_empty_c;
   assign w_wr = i_push & (~o_full_c | w_rd);

   // Storage, no reset needed
   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wptr] <= i_data;
   end

   // Pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_wr) r_wptr <= r_wptr + AW'(1);
         if (w_rd) r_rptr <= r_rptr + AW'(1);
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/mc_scratch_rsp.sv
// Responder end of the personality-to-MC interface backed by a 64-bit word
// scratch RAM. Stores write the RAM; loads read it and return
// {rdctl, data} in request order after RD_LAT pipe stages plus the
// response queue and registered output stage.
// Ports:
//   clk, reset_n                  - clock, asynchronous active-low reset
//   mc_req_ld / mc_req_st         - load / store request valid
//   mc_req_vadr                   - byte address, word index vadr[ADDR_W+2:3]
//   mc_req_wrd_rdctl              - store data, or load tag in [31:0]
//   mc_rd_rq_stall/mc_wr_rq_stall - registered back-pressure to initiator
//   mc_rsp_push/rdctl/data        - registered load response
//   mc_rsp_stall                  - initiator cannot accept a response
//   force_rd_stall/force_wr_stall - test controls for the stall outputs
//   ld_cnt / st_cnt               - accepted load / store counters (wrap)
//   err_proto                     - sticky protocol error
module mc_scratch_rsp
   import mc_if_pkg::*;
#(
   parameter int unsigned ADDR_W     = 10,
   parameter int unsigned RD_LAT     = 4,
   parameter int unsigned RSPQ_DEPTH = 16
)
(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  mc_req_ld,
   input  logic                  mc_req_st,
   input  logic [REQ_ADDR_W-1:0] mc_req_vadr,
   input  logic [REQ_DATA_W-1:0] mc_req_wrd_rdctl,
   output logic                  mc_rd_rq_stall,
   output logic                  mc_wr_rq_stall,
   output logic                  mc_rsp_push,
   output logic [RDCTL_W-1:0]    mc_rsp_rdctl,
   output logic [REQ_DATA_W-1:0] mc_rsp_data,
   input  logic                  mc_rsp_stall,
   input  logic                  force_rd_stall,
   input  logic                  force_wr_stall,
   output logic [31:0]           ld_cnt,
   output logic [31:0]           st_cnt,
   output logic                  err_proto
);

   localparam int unsigned QCNT_W   = $clog2(RSPQ_DEPTH) + 1;
   // RD_LAT < RSPQ_DEPTH, so one extra bit holds queue count plus pipe valids
   localparam int unsigned OCC_W    = QCNT_W + 1;
   localparam int unsigned STALL_TH = RSPQ_DEPTH - 4;

   logic [REQ_DATA_W-1:0] r_ram [2**ADDR_W];
   rsp_t                  r_pd  [RD_LAT];
   logic [RD_LAT-1:0]     r_pv;

   logic              w_ld_acc;
   logic              w_st_acc;
   logic              w_err_both;
   logic [ADDR_W-1:0] w_idx;
   logic              w_pipe_out_v;
   logic              w_pop;
   logic              w_ovf;
   logic              w_q_full;
   logic              w_q_empty;
   logic [QCNT_W-1:0] w_q_count;
   rsp_t              w_head;
   logic [OCC_W-1:0]  w_occ;
   logic              w_unused_vadr;

   // Simultaneous load and store is a protocol error; both are dropped
   assign w_err_both = mc_req_ld & mc_req_st;
   assign w_ld_acc   = mc_req_ld & ~mc_req_st;
   assign w_st_acc   = mc_req_st & ~mc_req_ld;

   // Byte offset and high address bits are don't-care; high bits alias
   assign w_idx         = mc_req_vadr[ADDR_W+2:3];
   assign w_unused_vadr = ^{mc_req_vadr[REQ_ADDR_W-1:ADDR_W+3], mc_req_vadr[2:0]};

   assign w_pipe_out_v = r_pv[RD_LAT-1];
   assign w_pop        = ~w_q_empty & ~mc_rsp_stall;
   // Queue write while full is only lost when the head is not leaving
   assign w_ovf        = w_pipe_out_v & w_q_full & ~w_pop;

   // RAM and load data pipe; valids gate everything so no reset here
   always_ff @(posedge clk) begin
      if (w_st_acc) r_ram[w_idx] <= mc_req_wrd_rdctl;
      r_pd[0] <= '{rdctl: mc_req_wrd_rdctl[RDCTL_W-1:0], data: r_ram[w_idx]};
      for (int unsigned i = 1; i < RD_LAT; i++) begin
         r_pd[i] <= r_pd[i-1];
      end
   end

   // Load pipe valids
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pv <= '0;
      end else begin
         r_pv[0] <= w_ld_acc;
         for (int unsigned i = 1; i < RD_LAT; i++) begin
            r_pv[i] <= r_pv[i-1];
         end
      end
   end

   mc_rspq #(
      .DEPTH (RSPQ_DEPTH)
   ) u_rspq (
      .clk       (clk),
      .rst_n     (reset_n),
      .i_push    (w_pipe_out_v),
      .i_pop     (w_pop),
      .i_data    (r_pd[RD_LAT-1]),
      .o_head_c  (w_head),
      .o_full_c  (w_q_full),
      .o_empty_c (w_q_empty),
      .o_count   (w_q_count)
   );

   // Occupancy counts in-flight loads that will land in the queue
   always_comb begin
      w_occ = OCC_W'(w_q_count);
      for (int unsigned i = 0; i < RD_LAT; i++) begin
         w_occ = w_occ + OCC_W'(r_pv[i]);
      end
   end

   // Registered response, stall, counter and error outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mc_rsp_push    <= 1'b0;
         mc_rsp_rdctl   <= '0;
         mc_rsp_data    <= '0;
         mc_rd_rq_stall <= 1'b0;
         mc_wr_rq_stall <= 1'b0;
         ld_cnt         <= '0;
         st_cnt         <= '0;
         err_proto      <= 1'b0;
      end else begin
         mc_rsp_push <= w_pop;
         if (w_pop) begin
            mc_rsp_rdctl <= w_head.rdctl;
            mc_rsp_data  <= w_head.data;
         end
         mc_rd_rq_stall <= (w_occ >= OCC_W'(STALL_TH)) | force_rd_stall;
         mc_wr_rq_stall <= force_wr_stall;
         ld_cnt         <= ld_cnt + 32'(w_ld_acc);
         st_cnt         <= st_cnt + 32'(w_st_acc);
         err_proto      <= err_proto | w_err_both | w_ovf;
      end
   end

endmodule

// File: tb/tb_mc_scratch_rsp.sv
// Bench for mc_scratch_rsp: directed stimulus queues expected responses,
// a negedge monitor pops and compares every pushed response.
module tb_mc_scratch_rsp;
   import mc_if_pkg::*;

   localparam int unsigned ADDR_W     = 10;
   localparam int unsigned RD_LAT     = 4;
   localparam int unsigned RSPQ_DEPTH = 16;

   logic                  clk = 1'b0;
   logic                  reset_n;
   logic                  mc_req_ld;
   logic                  mc_req_st;
   logic [REQ_ADDR_W-1:0] mc_req_vadr;
   logic [REQ_DATA_W-1:0] mc_req_wrd_rdctl;
   logic                  mc_rd_rq_stall;
   logic                  mc_wr_rq_stall;
   logic                  mc_rsp_push;
   logic [RDCTL_W-1:0]    mc_rsp_rdctl;
   logic [REQ_DATA_W-1:0] mc_rsp_data;
   logic                  mc_rsp_stall;
   logic                  force_rd_stall;
   logic                  force_wr_stall;
   logic [31:0]           ld_cnt;
   logic [31:0]           st_cnt;
   logic                  err_proto;

   mc_scratch_rsp #(
      .ADDR_W     (ADDR_W),
      .RD_LAT     (RD_LAT),
      .RSPQ_DEPTH (RSPQ_DEPTH)
   ) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .mc_req_ld        (mc_req_ld),
      .mc_req_st        (mc_req_st),
      .mc_req_vadr      (mc_req_vadr),
      .mc_req_wrd_rdctl (mc_req_wrd_rdctl),
      .mc_rd_rq_stall   (mc_rd_rq_stall),
      .mc_wr_rq_stall   (mc_wr_rq_stall),
      .mc_rsp_push      (mc_rsp_push),
      .mc_rsp_rdctl     (mc_rsp_rdctl),
      .mc_rsp_data      (mc_rsp_data),
      .mc_rsp_stall     (mc_rsp_stall),
      .force_rd_stall   (force_rd_stall),
      .force_wr_stall   (force_wr_stall),
      .ld_cnt           (ld_cnt),
      .st_cnt           (st_cnt),
      .err_proto        (err_proto)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [RDCTL_W-1:0]    rdctl;
      logic [REQ_DATA_W-1:0] data;
      int                    cyc;   // negedge cycle of expected push, -1 = unchecked
   } exp_t;

   exp_t sb[$];
   exp_t m_e;
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (mc_rsp_push === 1'b1) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_push: got rdctl %h data %h, expected no response (cycle %0d)",
                     mc_rsp_rdctl, mc_rsp_data, cyc);
         end else begin
            m_e = sb.pop_front();
            check("rsp_rdctl", 64'(mc_rsp_rdctl), 64'(m_e.rdctl));
            check("rsp_data", mc_rsp_data, m_e.data);
            if (m_e.cyc >= 0) check("rsp_cycle", 64'(cyc), 64'(m_e.cyc));
         end
      end
   end

   task automatic req(input logic ld, input logic st, input logic [47:0] va, input logic [63:0] wd);
      @(negedge clk);
      mc_req_ld        = ld;
      mc_req_st        = st;
      mc_req_vadr      = va;
      mc_req_wrd_rdctl = wd;
   endtask

   task automatic idle(input int n);
      repeat (n) req(1'b0, 1'b0, 48'h0, 64'h0);
   endtask

   task automatic do_st(input logic [47:0] va, input logic [63:0] wd);
      req(1'b0, 1'b1, va, wd);
   endtask

   // Upper half of wrd_rdctl is junk on loads and must not reach the tag
   task automatic do_ld(input logic [47:0] va, input logic [31:0] tag,
                        input logic [63:0] exp_data, input bit chk_lat);
      exp_t e;
      req(1'b1, 1'b0, va, {32'hCAFE_F00D, tag});
      e.rdctl = tag;
      e.data  = exp_data;
      e.cyc   = chk_lat ? (cyc + 1 + int'(RD_LAT) + 1) : -1;
      sb.push_back(e);
   endtask

   task automatic wait_drain(input int max_cyc);
      int n;
      n = 0;
      while (sb.size() != 0 && n < max_cyc) begin
         idle(1);
         n++;
      end
      check("drain_timeout", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n          = 1'b1;
      mc_req_ld        = 1'b0;
      mc_req_st        = 1'b0;
      mc_req_vadr      = '0;
      mc_req_wrd_rdctl = '0;
      mc_rsp_stall     = 1'b0;
      force_rd_stall   = 1'b0;
      force_wr_stall   = 1'b0;
      #2 reset_n = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_push", 64'(mc_rsp_push), 64'd0);
      check("rst_rdctl", 64'(mc_rsp_rdctl), 64'd0);
      check("rst_data", mc_rsp_data, 64'd0);
      check("rst_rd_stall", 64'(mc_rd_rq_stall), 64'd0);
      check("rst_wr_stall", 64'(mc_wr_rq_stall), 64'd0);
      check("rst_ld_cnt", 64'(ld_cnt), 64'd0);
      check("rst_st_cnt", 64'(st_cnt), 64'd0);
      check("rst_err", 64'(err_proto), 64'd0);
      reset_n = 1'b1;
      idle(2);

      // 1. Write then read next cycle
      do_st(48'h100, 64'hDEADBEEF_00000001);
      do_ld(48'h100, 32'h5A, 64'hDEADBEEF_00000001, 1'b1);
      wait_drain(30);
      check("t1_st_cnt", 64'(st_cnt), 64'd1);
      check("t1_ld_cnt", 64'(ld_cnt), 64'd1);

      // 2. Back-to-back loads, high/low address bits set to check aliasing
      for (int i = 0; i < 8; i++)
         do_st(48'(i * 8), 64'hA5A5_0000_0000_0000 | 64'(i));
      for (int i = 0; i < 8; i++)
         do_ld(48'hF000_0000_0000 | 48'(i * 8) | 48'h5, 32'(i),
               64'hA5A5_0000_0000_0000 | 64'(i), 1'b1);
      wait_drain(40);
      check("t2_st_cnt", 64'(st_cnt), 64'd9);
      check("t2_ld_cnt", 64'(ld_cnt), 64'd9);

      // 3. Back-pressure: 12 loads with response stall held
      mc_rsp_stall = 1'b1;
      for (int i = 0; i < 12; i++)
         do_ld(48'((i % 8) * 8), 32'h100 + 32'(i),
               64'hA5A5_0000_0000_0000 | 64'(i % 8), 1'b0);
      idle(1);
      check("t3_rd_stall_at11", 64'(mc_rd_rq_stall), 64'd0);
      idle(1);
      check("t3_rd_stall_at12", 64'(mc_rd_rq_stall), 64'd1);
      idle(8);
      check("t3_rd_stall_hold", 64'(mc_rd_rq_stall), 64'd1);
      check("t3_sb_held", 64'(sb.size()), 64'd12);
      mc_rsp_stall = 1'b0;
      wait_drain(40);
      idle(2);
      check("t3_err", 64'(err_proto), 64'd0);
      check("t3_rd_stall_rel", 64'(mc_rd_rq_stall), 64'd0);
      check("t3_ld_cnt", 64'(ld_cnt), 64'd21);

      // 4. Protocol error: ld and st together
      req(1'b1, 1'b1, 48'h100, 64'h1111_2222_3333_4444);
      idle(1);
      check("t4_err_set", 64'(err_proto), 64'd1);
      idle(10);
      check("t4_err_sticky", 64'(err_proto), 64'd1);
      check("t4_ld_cnt", 64'(ld_cnt), 64'd21);
      check("t4_st_cnt", 64'(st_cnt), 64'd9);
      do_ld(48'h100, 32'h77, 64'hDEADBEEF_00000001, 1'b1);
      wait_drain(30);

      // 5. Forced stalls
      @(negedge clk);
      force_wr_stall = 1'b1;
      @(negedge clk);
      check("t5_wr_stall_on", 64'(mc_wr_rq_stall), 64'd1);
      force_wr_stall = 1'b0;
      @(negedge clk);
      check("t5_wr_stall_off", 64'(mc_wr_rq_stall), 64'd0);
      check("t5_rd_stall_pre", 64'(mc_rd_rq_stall), 64'd0);
      force_rd_stall = 1'b1;
      @(negedge clk);
      check("t5_rd_stall_on", 64'(mc_rd_rq_stall), 64'd1);
      force_rd_stall = 1'b0;
      @(negedge clk);
      check("t5_rd_stall_off", 64'(mc_rd_rq_stall), 64'd0);

      // 6. Reset with loads in flight
      do_ld(48'h0,  32'h300, 64'hA5A5_0000_0000_0000, 1'b1);
      do_ld(48'h8,  32'h301, 64'hA5A5_0000_0000_0001, 1'b1);
      do_ld(48'h10, 32'h302, 64'hA5A5_0000_0000_0002, 1'b1);
      idle(1);
      @(negedge clk);
      reset_n = 1'b0;
      sb.delete();
      #1;
      check("t6_rst_push", 64'(mc_rsp_push), 64'd0);
      check("t6_rst_ld_cnt", 64'(ld_cnt), 64'd0);
      check("t6_rst_st_cnt", 64'(st_cnt), 64'd0);
      check("t6_rst_err", 64'(err_proto), 64'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      idle(15);
      check("t6_ld_cnt_after", 64'(ld_cnt), 64'd0);
      do_ld(48'h100, 32'hABC, 64'hDEADBEEF_00000001, 1'b1);
      wait_drain(30);
      check("t6_ld_cnt_final", 64'(ld_cnt), 64'd1);
      check("t6_err_final", 64'(err_proto), 64'd0);

      idle(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mc_scratch_rsp.md
Name: mc_scratch_rsp

Overview:
Responder end of the personality-to-MC request/response interface. It accepts load and store requests from an initiator such as a vector unit and services them from an internal 64-bit word scratch RAM. Load responses carry the request's rdctl tag and return in request order after a fixed pipeline latency. Used as an on-die scratch memory and as the MC stand-in for unit-level benches of request-issuing personalities.

Parameters:
ADDR_W, 10, log2 of RAM depth in 64-bit words (1024 words)
RD_LAT, 4, load pipeline stages between request accept and response-queue write (>=1)
RSPQ_DEPTH, 16, response queue entries (power of 2, > RD_LAT+4)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
mc_req_ld  in  1  load request valid
mc_req_st  in  1  store request valid
mc_req_vadr  in  48  byte address; word index = vadr[ADDR_W+2:3]
mc_req_wrd_rdctl  in  64  store data, or load rdctl in [31:0]
mc_rd_rq_stall  out  1  load back-pressure to initiator
mc_wr_rq_stall  out  1  store back-pressure to initiator
mc_rsp_push  out  1  load response valid
mc_rsp_rdctl  out  32  returned tag, equals the request's wrd_rdctl[31:0]
mc_rsp_data  out  64  load data
mc_rsp_stall  in  1  initiator cannot take a response this cycle
force_rd_stall  in  1  test control: OR'd into rd stall
force_wr_stall  in  1  test control: sole source of wr stall
ld_cnt  out  32  accepted loads, wraps
st_cnt  out  32  accepted stores, wraps
err_proto  out  1  sticky protocol error

Behaviour:
- Reset, asynchronous on reset_n low: all outputs 0, pipe valids 0, queue empty, counters 0, err_proto 0. RAM contents are not reset. Reset mid-operation drops in-flight loads; no response is emitted for them.
- Accept rule: requests are accepted every cycle regardless of the stall outputs, because the initiator has registered skid.
- ld and st high in the same cycle: both are dropped and err_proto is set.
- Store, cycle T: RAM[idx] <= wrd_rdctl, visible to a load accepted at T+1. No response is generated. st_cnt increments.
- Load, cycle T: RAM is read synchronously and {data, rdctl[31:0]} enters an RD_LAT-stage valid pipe. The entry is written to the response queue at T+RD_LAT. ld_cnt increments.
- Address: bits above ADDR_W+2 and bits [2:0] are ignored; out-of-range addresses alias.
- Response output: registered. When the queue is non-empty and mc_rsp_stall=0, pop the head into the output regs and drive push=1 the next cycle. Otherwise push=0 and rdctl/data hold their last values.
- Latency: empty queue and no stall gives push at exactly T+RD_LAT+2. Responses stay in request order.
- mc_rsp_stall timing: sampled combinationally for the pop decision. A response already registered is not retracted.
- Occupancy: occ = queue count + pipe valids.
- mc_rd_rq_stall is registered: next = (occ >= RSPQ_DEPTH-4) | force_rd_stall. The margin covers two-cycle initiator skid plus the same-cycle accept.
- mc_wr_rq_stall is registered: next = force_wr_stall. The store path is never full.
- Overflow: a pipe entry arriving when the queue is full is dropped and err_proto is set. This is unreachable with a compliant initiator.
- Simultaneous queue write and pop when full: allowed, and is not an overflow.

Decomposition:
- Shared package mc_if_pkg holds REQ_ADDR_W=48, REQ_DATA_W=64, RDCTL_W=32, and a rsp_t struct {rdctl, data}.
- One sub-module, mc_rspq: a synchronous FIFO of rsp_t with count, push/pop, full/empty and async active-low reset. The RAM is an inferred array inside the top.

Test Plan:
1. Write-then-read: st vadr 0x100 data 0xDEADBEEF_00000001, then ld vadr 0x100 rdctl 0x5A next cycle -> push at ld+6 with data 0xDEADBEEF_00000001 and rdctl 0x0000005A. st_cnt=1, ld_cnt=1.
2. Back-to-back: 8 loads, word indices 0..7, rdctl 0..7 -> 8 consecutive push cycles in order, first at T+6.
3. Back-pressure: hold mc_rsp_stall=1 while issuing 12 loads -> mc_rd_rq_stall rises after occ reaches 12. Release stall -> all 12 responses drain in order, err_proto stays 0.
4. Protocol error: ld and st both high for 1 cycle -> err_proto=1 and sticky, RAM unchanged, no response, counters unchanged.
5. Force stalls: force_wr_stall=1 -> mc_wr_rq_stall=1 one cycle later. force_rd_stall=1 with an empty queue -> mc_rd_rq_stall=1 one cycle later.
6. Reset mid-flight: issue 3 loads, then pulse reset_n low before any push -> no push afterwards, all counters 0. A subsequent load of an address written before reset returns the pre-reset data.
